dtree_seq_eval: RTL and testbench



---
 rtl/dtree_pkg.sv | 35 +++
 rtl/dtree_node_cmp.sv | 38 +++
 rtl/dtree_seq_eval.sv | 109 ++++++++++
 tb/tb_dtree_seq_eval.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared types and sizing for the sequential decision-tree evaluator.
// A node word packs is_leaf, feat_idx, prec, thr, left, right, cls, MSB first.
package dtree_pkg;

  localparam int unsigned N_FEAT    = 18;
  localparam int unsigned FEAT_W    = 8;
  localparam int unsigned N_NODES   = 64;
  localparam int unsigned CLASS_W   = 2;
  localparam int unsigned MAX_DEPTH = 16;

  localparam int unsigned FEAT_IW = $clog2(N_FEAT);
  localparam int unsigned NODE_AW = $clog2(N_NODES);
  localparam int unsigned PREC_W  = $clog2(FEAT_W) + 1;
  localparam int unsigned DEPTH_W = $clog2(MAX_DEPTH);
  localparam int unsigned NODE_W  = 1 + FEAT_IW + PREC_W + FEAT_W + 2 * NODE_AW + CLASS_W;

  typedef struct packed {
    logic                 is_leaf;
    logic [FEAT_IW-1:0]   feat_idx;
    logic [PREC_W-1:0]    prec;
    logic [FEAT_W-1:0]    thr;
    logic [NODE_AW-1:0]   left;
    logic [NODE_AW-1:0]   right;
    logic [CLASS_W-1:0]   cls;
  } dtree_node_t;

  typedef enum logic [1:0] {StIdle, StWalk, StDone} dtree_state_e;

  // Right-shift that keeps the top prec bits; 0 (and out-of-range) means full precision.
  function automatic logic [PREC_W-1:0] prec_shift(logic [PREC_W-1:0] prec);
    if (prec == '0 || 32'(prec) > FEAT_W) return '0;
    return PREC_W'(FEAT_W) - prec;
  endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Combinational evaluation of one tree node against the latched feature vector.
module dtree_node_cmp
  import dtree_pkg::*;
(
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  input  dtree_node_t              node,
  output logic [NODE_AW-1:0]       next_ptr,
  output logic                     is_leaf,
  output logic                     fault
);

  logic [FEAT_W-1:0] sel;
  logic [FEAT_W-1:0] trunc;
  logic              feat_bad;
  logic              ptr_bad;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < N_FEAT; i++) begin
      if (node.feat_idx == FEAT_IW'(i)) sel = feat[i*FEAT_W +: FEAT_W];
    end
  end

  assign feat_bad = 32'(node.feat_idx) >= N_FEAT;
  assign trunc    = sel >> prec_shift(node.prec);
  assign next_ptr = (trunc <= node.thr) ? node.left : node.right;

  // Child pointers can only overflow the table when its depth is not a power of two.
  if ((1 << NODE_AW) > N_NODES) begin : g_ptr_chk
    assign ptr_bad = 32'(next_ptr) >= N_NODES;
  end else begin : g_no_ptr_chk
    assign ptr_bad = 1'b0;
  end

  assign is_leaf = node.is_leaf;
  assign fault   = !node.is_leaf && (feat_bad || ptr_bad);

endmodule

// File: rtl/dtree_seq_eval.sv
// Programmable decision-tree classifier: latches a feature vector and walks the
// runtime-loaded node table one node per cycle from root to leaf.
module dtree_seq_eval
  import dtree_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NODE_AW-1:0]       cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata,
  input  logic                     cfg_done
);

  dtree_state_e             state_q, state_d;
  logic [NODE_AW-1:0]       ptr_q, ptr_d;
  logic [DEPTH_W-1:0]       depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0] feat_q, feat_d;
  logic [CLASS_W-1:0]       class_q, class_d;
  logic                     err_q, err_d;

  dtree_node_t              node_tab_q [N_NODES];
  dtree_node_t              cur_node;
  logic [NODE_AW-1:0]       next_ptr;
  logic                     is_leaf;
  logic                     fault;

  // Table survives reset; it is owned by the configuration side.
  always_ff @(posedge clk) begin
    if (cfg_we && state_q == StIdle) node_tab_q[cfg_addr] <= dtree_node_t'(cfg_wdata);
  end

  assign cur_node = node_tab_q[ptr_q];

  dtree_node_cmp u_node_cmp (
    .feat     (feat_q),
    .node     (cur_node),
    .next_ptr (next_ptr),
    .is_leaf  (is_leaf),
    .fault    (fault)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    feat_d  = feat_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && cfg_done) begin
          feat_d  = in_feat;
          ptr_d   = '0;
          depth_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (is_leaf) begin
          class_d = cur_node.cls;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (fault || depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          ptr_d   = next_ptr;
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      depth_q <= '0;
      feat_q  <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      feat_q  <= feat_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && cfg_done;
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Self-checking bench for dtree_seq_eval: directed trees plus random tables and vectors,
// checked against a tree-walking reference model.
module tb_dtree_seq_eval;
  import dtree_pkg::*;

  localparam int FW = N_FEAT * FEAT_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FW-1:0]      in_feat;
  logic               out_valid;
  logic               out_ready;
  logic [CLASS_W-1:0] out_class;
  logic               out_err;
  logic               cfg_we;
  logic [NODE_AW-1:0] cfg_addr;
  logic [NODE_W-1:0]  cfg_wdata;
  logic               cfg_done;

  dtree_seq_eval dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_done  (cfg_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dtree_node_t        mtab [N_NODES];
  dtree_node_t        nz = '0;
  bit                 pending = 0;
  bit                 seen = 0;
  int                 acc_cyc = 0;
  int                 exp_k = 0;
  logic [CLASS_W-1:0] exp_cls, held_cls, last_cls;
  logic               exp_err, held_err, last_err;
  int                 last_lat = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the model table from the root using the compare rule directly.
  function automatic void model(input logic [FW-1:0] f, output logic [CLASS_W-1:0] cls,
                                output logic err, output int k);
    int ptr, fi, p, x, t, child;
    dtree_node_t n;
    ptr = 0;
    cls = '0;
    err = 1'b1;
    k   = MAX_DEPTH;
    for (int d = 0; d < int'(MAX_DEPTH); d++) begin
      n = mtab[ptr];
      k = d + 1;
      if (n.is_leaf) begin
        cls = n.cls;
        err = 1'b0;
        return;
      end
      fi = int'(n.feat_idx);
      if (fi >= int'(N_FEAT)) return;
      p = (n.prec == 0) ? int'(FEAT_W) : int'(n.prec);
      x = int'(f[fi*FEAT_W +: FEAT_W]);
      t = x / (1 << (int'(FEAT_W) - p));
      child = (t <= int'(n.thr)) ? int'(n.left) : int'(n.right);
      if (child >= int'(N_NODES)) return;
      if (d == int'(MAX_DEPTH) - 1) return;
      ptr = child;
    end
  endfunction

  // Compare process: handshake legality, latency, result and hold stability.
  always @(negedge clk) begin
    if (rst) begin
      pending = 0;
      seen    = 0;
    end else begin
      check("in_ready", in_ready, 32'(!pending && cfg_done));
      if (in_valid && in_ready) begin
        model(in_feat, exp_cls, exp_err, exp_k);
        pending = 1;
        seen    = 0;
        acc_cyc = cyc;
      end else if (!pending) begin
        check("idle_out_valid", out_valid, 0);
      end else if (out_valid) begin
        if (!seen) begin
          check("latency", cyc - acc_cyc, exp_k + 1);
          check("out_class", out_class, exp_cls);
          check("out_err", out_err, exp_err);
          last_lat = cyc - acc_cyc;
          last_cls = out_class;
          last_err = out_err;
          held_cls = out_class;
          held_err = out_err;
          seen     = 1;
        end else begin
          check("hold_class", out_class, held_cls);
          check("hold_err", out_err, held_err);
        end
        if (out_ready) pending = 0;
      end else if (cyc - acc_cyc > int'(MAX_DEPTH) + 2) begin
        check("walk_timeout", 0, 1);
        pending = 0;
      end
    end
  end

  function automatic dtree_node_t leaf(input int c);
    dtree_node_t n = '0;
    n.is_leaf = 1'b1;
    n.cls     = CLASS_W'(c);
    return n;
  endfunction

  function automatic dtree_node_t inode(input int fi, input int pr, input int th,
                                        input int l, input int r);
    dtree_node_t n = '0;
    n.feat_idx = FEAT_IW'(fi);
    n.prec     = PREC_W'(pr);
    n.thr      = FEAT_W'(th);
    n.left     = NODE_AW'(l);
    n.right    = NODE_AW'(r);
    n.cls      = CLASS_W'($urandom);
    return n;
  endfunction

  function automatic logic [FW-1:0] rand_feat();
    logic [FW-1:0] v;
    for (int i = 0; i < int'(N_FEAT); i++) v[i*FEAT_W +: FEAT_W] = FEAT_W'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_node(input int a, input dtree_node_t n);
    cfg_we    = 1'b1;
    cfg_addr  = NODE_AW'(a);
    cfg_wdata = n;
    mtab[a]   = n;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic send(input logic [FW-1:0] f, input bit wr, input int waddr, input dtree_node_t wn);
    int n = 0;
    in_feat  = f;
    in_valid = 1'b1;
    if (wr) begin
      cfg_we      = 1'b1;
      cfg_addr    = NODE_AW'(waddr);
      cfg_wdata   = wn;
      mtab[waddr] = wn;
    end
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    in_feat  = rand_feat();
  endtask

  // Waits for the result, stalls it for 'hold' cycles (optionally poking the table), then drains.
  task automatic wait_result(input int hold, input bit wr_during);
    int n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      in_feat = rand_feat();
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("result_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      if (wr_during) begin
        cfg_we    = 1'b1;
        cfg_addr  = NODE_AW'(1);
        cfg_wdata = leaf(0);
      end
      @(negedge clk);
    end
    tick();
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tick();
    out_ready = 1'b0;
  endtask

  function automatic logic [FW-1:0] feat_with7(input logic [FEAT_W-1:0] b);
    logic [FW-1:0] v = rand_feat();
    v[7*FEAT_W +: FEAT_W] = b;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0; cfg_done = 1'b0;
    cfg_addr = '0; cfg_wdata = '0; in_feat = '0;
    for (int i = 0; i < int'(N_NODES); i++) mtab[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_class", out_class, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready_cfg0", in_ready, 0);
    tick();

    // Root is a leaf
    write_node(0, leaf(2));
    cfg_done = 1'b1;
    send(rand_feat(), 0, 0, nz);
    wait_result(0, 0);
    check("leaf_cls", last_cls, 2);
    check("leaf_err", last_err, 0);
    check("leaf_lat", last_lat, 2);

    // Depth-2 tree on feature 7, top nibble vs 10
    write_node(0, inode(7, 4, 10, 1, 2));
    write_node(1, leaf(1));
    write_node(2, leaf(3));
    send(feat_with7(8'hA0), 0, 0, nz);
    wait_result(0, 0);
    check("d2_a0_cls", last_cls, 1);
    check("d2_a0_lat", last_lat, 3);
    send(feat_with7(8'hB0), 0, 0, nz);
    wait_result(1, 0);
    check("d2_b0_cls", last_cls, 3);
    check("d2_b0_lat", last_lat, 3);

    // Self-loop hits the depth limit
    write_node(0, inode(0, 8, 0, 0, 0));
    send(rand_feat(), 0, 0, nz);
    wait_result(0, 0);
    check("loop_err", last_err, 1);
    check("loop_cls", last_cls, 0);
    check("loop_lat", last_lat, MAX_DEPTH + 1);

    // Feature index out of range
    write_node(0, inode(20, 8, 0, 1, 2));
    send(rand_feat(), 0, 0, nz);
    wait_result(0, 0);
    check("badfeat_err", last_err, 1);
    check("badfeat_lat", last_lat, 2);

    // Backpressure with ignored table writes, then read-back
    write_node(0, inode(7, 4, 10, 1, 2));
    send(feat_with7(8'hA0), 0, 0, nz);
    wait_result(10, 1);
    check("bp_cls", last_cls, 1);
    send(feat_with7(8'hA0), 0, 0, nz);
    wait_result(0, 0);
    check("bp_readback_cls", last_cls, 1);

    // Write and accept in the same cycle: walk sees the new node
    send(feat_with7(8'h30), 1, 1, leaf(3));
    wait_result(0, 0);
    check("wr_accept_cls", last_cls, 3);
    write_node(1, leaf(1));

    // Reset mid-walk discards the result; table is kept
    send(feat_with7(8'hB0), 0, 0, nz);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    send(feat_with7(8'hB0), 0, 0, nz);
    wait_result(0, 0);
    check("post_rst_cls", last_cls, 3);

    // cfg_done drop during the walk only blocks the next acceptance
    send(feat_with7(8'h10), 0, 0, nz);
    cfg_done = 1'b0;
    wait_result(2, 0);
    check("cfgdrop_cls", last_cls, 1);
    cfg_done = 1'b1;

    // Random tables and vectors
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < int'(N_NODES); i++) begin
        if ($urandom_range(0, 2) == 0 || i >= 56)
          write_node(i, leaf(int'($urandom_range(0, 3))));
        else
          write_node(i, inode(int'($urandom_range(0, 19)), int'($urandom_range(0, 8)),
                              int'($urandom_range(0, 255)), int'($urandom_range(0, 63)),
                              int'($urandom_range(0, 63))));
      end
      for (int v = 0; v < 100; v++) begin
        send(rand_feat(), 0, 0, nz);
        if ($urandom_range(0, 4) == 0) cfg_done = 1'b0;
        wait_result(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        cfg_done = 1'b1;
      end
    end

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
